// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: raster timing, framebuffer read addressing and vblank-only buffer swap.
// Optional macro SCANOUT_BORDER_EN forces pixel=1 on the outermost active rows/columns.
module framebuffer_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE_SHIFT = 1,
  parameter int RD_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [16:0] addrb,
  input  logic        doutb,
  output logic        ab,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pixel,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int LAT = RD_LAT + 2;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [16:0]   FB_W   = 17'(H_ACTIVE >> SCALE_SHIFT);

  typedef enum logic {IDLE, SWAP} state_t;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [16:0]   row_base;
  logic          active, h_last, at_check;
  state_t        state, state_next;

  assign h_last   = h_cnt == H_LAST;
  assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign at_check = (h_cnt == '0) && (v_cnt == V_ACT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      row_base <= '0;
      addrb    <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) begin
        v_cnt    <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        row_base <= (v_cnt == V_LAST) ? '0 :
                    ((v_cnt < V_ACT) && ((v_cnt & V_MASK) == V_MASK)) ? row_base + FB_W : row_base;
      end
      addrb <= active ? row_base + 17'(h_cnt >> SCALE_SHIFT) : '0;
    end
  end

  // Timing bits ride a LAT-1 deep delay line; the output register supplies the last stage.
`ifdef SCANOUT_BORDER_EN
  localparam int PW = 5;
  localparam logic [HW-1:0] H_END = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_END = VW'(V_ACTIVE - 1);
  logic edge_cell;
  assign edge_cell = (h_cnt == '0) || (h_cnt == H_END) || (v_cnt == '0) || (v_cnt == V_END);
`else
  localparam int PW = 4;
`endif

  logic [PW-1:0] raw;
  logic [PW-1:0] pipe [LAT-1];
  logic [PW-1:0] tap;

`ifdef SCANOUT_BORDER_EN
  assign raw = {edge_cell, (h_cnt == '0) && (v_cnt == '0),
                (v_cnt >= VS_BEG) && (v_cnt < VS_END),
                (h_cnt >= HS_BEG) && (h_cnt < HS_END), active};
`else
  assign raw = {(h_cnt == '0) && (v_cnt == '0),
                (v_cnt >= VS_BEG) && (v_cnt < VS_END),
                (h_cnt >= HS_BEG) && (h_cnt < HS_END), active};
`endif
  assign tap = pipe[LAT-2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
      pixel       <= 1'b0;
    end else begin
      pipe[0] <= raw;
      for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
      de          <= tap[0];
      hsync       <= tap[1] ? HS_POL : ~HS_POL;
      vsync       <= tap[2] ? VS_POL : ~VS_POL;
      frame_start <= tap[3];
`ifdef SCANOUT_BORDER_EN
      pixel       <= tap[0] & (doutb | tap[4]);
`else
      pixel       <= tap[0] & doutb;
`endif
    end
  end

  // Swap point sits at the top of vblank, so every in-flight read has retired.
  always_comb state_next = (state == IDLE && at_check && swap_req) ? SWAP : IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ab    <= 1'b0;
    end else begin
      state <= state_next;
      ab    <= ab ^ (state_next == SWAP);
    end
  end

  assign swap_ack = state == SWAP;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: directed checks on a shrunken 16x12 raster (8x6 active, 4x3 cells).
module tb_framebuffer_scanout;
  localparam int HT = 16, VT = 12, FR = HT * VT;

  logic clk = 1'b0, rst = 1'b1, swap_req = 1'b0;
  logic doutb, ab, swap_ack, hsync, vsync, de, pixel, frame_start;
  logic [16:0] addrb;
  logic d1 = 1'b0, d2 = 1'b0;
  logic exp_ab = 1'b0;
  int checks = 0, errors = 0, n = 0;

  always #5 clk = ~clk;

  // Two-clock read model returning addrb[0]
  always @(posedge clk) begin
    d1 <= addrb[0];
    d2 <= d1;
  end
  assign doutb = d2;

  framebuffer_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_SHIFT(1), .RD_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .addrb(addrb), .doutb(doutb), .ab(ab),
    .swap_req(swap_req), .swap_ack(swap_ack), .hsync(hsync), .vsync(vsync),
    .de(de), .pixel(pixel), .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addrb"}, 32'(addrb), 0);
    chk({tag, "_ab"}, 32'(ab), 0);
    chk({tag, "_ack"}, 32'(swap_ack), 0);
    chk({tag, "_de"}, 32'(de), 0);
    chk({tag, "_hs"}, 32'(hsync), 1);
    chk({tag, "_vs"}, 32'(vsync), 1);
    chk({tag, "_pix"}, 32'(pixel), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
  endtask

  // One clock; then compare every output with the expected raster position
  task automatic tick();
    int cur, q, qh, qv, p, ph, pv;
    logic req, e_ack, e_de, e_pix;
    cur = n;
    req = swap_req;
    @(posedge clk);
    #1;
    n++;
    e_ack = (cur % HT == 0) && ((cur / HT) % VT == 6) && req;
    exp_ab ^= e_ack;
    chk("ab", 32'(ab), 32'(exp_ab));
    chk("swap_ack", 32'(swap_ack), 32'(e_ack));
    q = n - 1;
    qh = q % HT;
    qv = (q / HT) % VT;
    chk("addrb", 32'(addrb), (qh < 8 && qv < 6) ? 32'((qv / 2) * 4 + qh / 2) : 0);
    if (n >= 4) begin
      p = n - 4;
      ph = p % HT;
      pv = (p / HT) % VT;
      e_de = ph < 8 && pv < 6;
`ifdef SCANOUT_BORDER_EN
      e_pix = e_de && (((ph / 2) % 2 == 1) || ph == 0 || ph == 7 || pv == 0 || pv == 5);
`else
      e_pix = e_de && ((ph / 2) % 2 == 1);
`endif
      chk("de", 32'(de), 32'(e_de));
      chk("hsync", 32'(hsync), (ph >= 10 && ph < 13) ? 0 : 1);
      chk("vsync", 32'(vsync), (pv >= 8 && pv < 10) ? 0 : 1);
      chk("frame_start", 32'(frame_start), (ph == 0 && pv == 0) ? 1 : 0);
      chk("pixel", 32'(pixel), 32'(e_pix));
    end else begin
      chk("de_pre", 32'(de), 0);
      chk("fs_pre", 32'(frame_start), 0);
      chk("hs_pre", 32'(hsync), 1);
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst0");
    rst = 1'b0;
    n = 0;
    run_to(3);
    chk("fs_before_lat", 32'(frame_start), 0);
    tick();
    chk("fs_at_lat", 32'(frame_start), 1);
    chk("de_at_lat", 32'(de), 1);
    run_to(22);
    chk("pix_col2_row1", 32'(pixel), 1);
    tick();
    tick();
    chk("pix_col4_row1", 32'(pixel), 0);
    run_to(32);
    swap_req = 1'b1;
    run_to(34);
    chk("addr_line2_start", 32'(addrb), 4);
    run_to(88);
    chk("addr_max", 32'(addrb), 11);
    run_to(96);
    chk("ab_at_check", 32'(ab), 0);
    tick();
    chk("ab_swapped", 32'(ab), 1);
    chk("ack_pulse", 32'(swap_ack), 1);
    tick();
    chk("ack_drop", 32'(swap_ack), 0);
    run_to(288);
    chk("ab_held", 32'(ab), 1);
    tick();
    chk("ab_reswap", 32'(ab), 0);
    swap_req = 1'b0;
    run_to(2 * FR + 97);
    swap_req = 1'b1;
    run_to(3 * FR + 96);
    chk("late_req_no_swap", 32'(ab), 0);
    tick();
    chk("late_req_swap", 32'(ab), 1);
    chk("late_req_ack", 32'(swap_ack), 1);
    swap_req = 1'b0;
    run_to(4 * FR + 35);
    rst = 1'b1;
    swap_req = 1'b1;
    #1;
    chk_reset("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ack", 32'(swap_ack), 0);
    chk("rst_req_ab", 32'(ab), 0);
    rst = 1'b0;
    swap_req = 1'b0;
    n = 0;
    exp_ab = 1'b0;
    run_to(3);
    chk("fs_before_lat2", 32'(frame_start), 0);
    tick();
    chk("fs_at_lat2", 32'(frame_start), 1);
    chk("ab_after_rst", 32'(ab), 0);
    run_to(FR + 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Video read side of the double-buffered life framebuffer. Generates raster timing for a 640x480 display. Drives the framebuffer read-port address and aligns the returned 1-bit cell data with sync/enable through a fixed pipeline. Owns the buffer-select line and swaps buffers only during vertical blanking, using a request/acknowledge handshake with the life engine.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `HS_POL`, 0, asserted level of `hsync`
- `VS_POL`, 0, asserted level of `vsync`
- `SCALE_SHIFT`, 1, upscale factor log2 (framebuffer is 320x240 cells)
- `RD_LAT`, 2, framebuffer read latency in clocks

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `addrb`  out  17  framebuffer read address, registered
- `doutb`  in  1  framebuffer read data, valid `RD_LAT` clocks after `addrb`
- `ab`  out  1  buffer select to framebuffer
- `swap_req`  in  1  level request from engine: new generation complete
- `swap_ack`  out  1  one-cycle pulse: buffers swapped
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `de`  out  1  display enable
- `pixel`  out  1  cell value, 0 when `de`=0
- `frame_start`  out  1  one-cycle pulse coincident with first `de` pixel of a frame

## Operation
- Counters `h_cnt` 0..H_TOTAL-1 and `v_cnt` 0..V_TOTAL-1.
  - H_TOTAL = sum of H params = 800; V_TOTAL = 525.
  - `h_cnt` wraps to 0 and `v_cnt` increments at H_TOTAL-1; `v_cnt` wraps to 0 after V_TOTAL-1.
- Active region: `h_cnt` < H_ACTIVE and `v_cnt` < V_ACTIVE.
- Sync windows:
  - hsync asserted for H_ACTIVE+H_FP <= `h_cnt` < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= `v_cnt` < V_ACTIVE+V_FP+V_SYNC.
- Address generation (no multiplier): FB_W = H_ACTIVE>>SCALE_SHIFT = 320.
  - `row_base` resets to 0 at `v_cnt` wrap.
  - `row_base` increases by FB_W at the end of each active line whose low SCALE_SHIFT bits of `v_cnt` are all ones.
  - In active region, `addrb` = `row_base` + (`h_cnt`>>SCALE_SHIFT); otherwise `addrb` = 0.
  - Maximum address is 76799; it never exceeds 17 bits.
- Pipeline: raw de/hsync/vsync/frame_start are delayed so outputs lag the counters by LAT = RD_LAT+2 clocks. `pixel` = `doutb` & de at the output register.
- Swap state (IDLE/SWAP):
  - Evaluated on the single cycle `h_cnt`=0, `v_cnt`=V_ACTIVE.
  - If `swap_req`=1: toggle `ab` and pulse `swap_ack` on the next clock, then return to IDLE.
  - If `swap_req`=0: no change.
  - Request is level-sensitive. If it is still high at the next frame's check point, the buffers swap again. The engine must drop it after `swap_ack`.
  - A request arriving after the check point waits for the next frame; no swap occurs mid-frame.

## Timing
- Reset values: counters 0, `row_base` 0, `addrb` 0, `ab` 0, `swap_ack` 0, `de` 0, `pixel` 0, `frame_start` 0, `hsync`=~HS_POL, `vsync`=~VS_POL; all pipeline stages are cleared.
- Reset mid-frame: all outputs reach reset values immediately. After release, counting restarts at (0,0) and the first `de`=1 and `frame_start`=1 appear LAT clocks later.
- `addrb` changes 1 clock after the counter; data returns RD_LAT clocks later and is registered 1 clock later.
- `ab` toggles at the same clock edge as the rising `swap_ack`. This is at least V_FP lines before the next active pixel, so all in-flight reads have completed.
- `swap_req` and `rst` high simultaneously: reset wins, no ack.

## Configuration
- `SCANOUT_BORDER_EN` defined: `pixel` is forced to 1 when the aligned position is the first or last active column or row, regardless of `doutb`.
- `SCANOUT_BORDER_EN` undefined: `pixel` = `doutb` & de only. No border logic is synthesized.

## Test plan
- Reset release, run 2 frames: hsync period 800 clocks, low for 96; vsync low 2 lines every 525 lines; de high for 640 clocks per line on 480 lines.
- Read model returns `addrb[0]`: `addrb` sequence on line 0 is 0,0,1,1,…,319,319. Lines 2–3 start at 320, line 479 ends at 76799. `pixel` toggles every 2 pixels, aligned to de with LAT=4.
- `swap_req`=1 mid-frame (line 100): `ab` stays 0 until the cycle after (0,480), then `ab`=1 with one `swap_ack` pulse. `swap_req` held high: `ab` returns to 0 the next frame.
- `swap_req` asserted on (1,480), one cycle after the check point: no swap this frame; swap occurs at the next frame's (0,480).
- `rst` pulsed at (300,200): outputs return immediately to reset values. `frame_start` fires exactly LAT clocks after release; `ab` is 0.
- With `SCANOUT_BORDER_EN` and a read model returning 0: `pixel`=1 only on columns 0/639 and rows 0/479. Without the macro, `pixel` is always 0.
